// File: rtl/k12a_inst_queue.sv
// -----------------------------------------------------------------------------
// k12a_inst_queue
//   Instruction register and prefetch queue for the K12A fetch path. Beats from
//   the narrow fetch bus are assembled MSB-first into whole instructions, which
//   are buffered in a DEPTH-entry circular FIFO and released to the decoder on
//   a valid/ready handshake. flush discards queued and partially assembled
//   instructions.
//
// Ports
//   clock       in   single clock, all state on the rising edge
//   reset       in   asynchronous, active-high reset
//   flush       in   synchronous discard of queue and assembler
//   byte_valid  in   byte_data holds a fetched beat
//   byte_ready  out  a beat is accepted this cycle
//   byte_data   in   fetched beat
//   inst_valid  out  inst holds the oldest complete instruction
//   inst_ready  in   decoder consumes inst this cycle
//   inst        out  oldest instruction, first-fetched beat in the MSBs
//   count       out  complete instructions held
//   beat_idx    out  beats held in the assembler
// -----------------------------------------------------------------------------
module k12a_inst_queue #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_INST = 2,
  parameter int DEPTH          = 2,
  localparam int INST_W        = DATA_WIDTH * BYTES_PER_INST,
  localparam int CNT_W         = $clog2(DEPTH + 1),
  localparam int IDX_W         = $clog2(BYTES_PER_INST + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic [DATA_WIDTH-1:0] byte_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_W-1:0]     inst,
  output logic [CNT_W-1:0]      count,
  output logic [IDX_W-1:0]      beat_idx
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // At least one assembler slot is declared so the array is never zero-width.
  localparam int ASM_N = (BYTES_PER_INST > 1) ? BYTES_PER_INST - 1 : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_INST - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // Slot 0 sits in the MSBs, so {asm_q, byte_data} is the finished instruction.
  logic [0:ASM_N-1][DATA_WIDTH-1:0] asm_q, asm_d;
  logic [IDX_W-1:0]                 beat_idx_q, beat_idx_d;
  logic [INST_W-1:0]                mem_q [DEPTH];
  logic [INST_W-1:0]                mem_d [DEPTH];
  logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;

  logic              last_beat;
  logic              full;
  logic              accept;
  logic              push;
  logic              pop;
  logic [INST_W-1:0] push_data;

  // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  generate
    if (BYTES_PER_INST > 1) begin : g_multi_beat
      assign push_data = {asm_q, byte_data};
    end else begin : g_single_beat
      assign push_data = byte_data;
    end
  endgenerate

  // Handshake and status. byte_ready depends only on state, which keeps every
  // port-to-port path registered.
  always_comb begin
    last_beat  = (beat_idx_q == LAST_IDX);
    full       = (count_q == FULL_CNT);
    byte_ready = ~(last_beat & full);
    inst_valid = (count_q != '0);
    accept     = byte_valid & byte_ready;
    pop        = inst_valid & inst_ready;
    push       = accept & last_beat;
    inst       = inst_valid ? mem_q[rd_ptr_q] : '0;
    count      = count_q;
    beat_idx   = beat_idx_q;
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    asm_d      = asm_q;
    beat_idx_d = beat_idx_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (flush) begin
      // Flush wins over any accept or pop in the same cycle.
      beat_idx_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (accept) begin
        if (last_beat) begin
          beat_idx_d = '0;
        end else begin
          for (int i = 0; i < ASM_N; i++) begin
            if (beat_idx_q == IDX_W'(i)) asm_d[i] = byte_data;
          end
          beat_idx_d = beat_idx_q + IDX_W'(1);
        end
      end

      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end

      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      asm_q      <= '0;
      beat_idx_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      // NOTE: the FIFO storage is cleared on reset because its contents are
      // defined as zero afterwards; this keeps the array in flops, not RAM.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      asm_q      <= asm_d;
      beat_idx_q <= beat_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule
